// File: rtl/edge_event_player_if.sv
// rtl/edge_event_player_if.sv - event input and level/status outputs of the edge event player
interface edge_event_player_if;
  logic [1:0] event_code;
  logic       signal;
  logic       busy;
  logic       overflow;

  modport master (output event_code, input signal, input busy, input overflow);
  modport slave  (input event_code, output signal, output busy, output overflow);
endinterface

// File: rtl/edge_event_player.sv
// rtl/edge_event_player.sv - replays queued rise/fall events as a level with a minimum hold time
module edge_event_player #(
  parameter int   HOLD_CYCLES = 4,
  parameter int   DEPTH       = 4,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  edge_event_player_if.slave   bus
);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          mem [DEPTH];
  logic          tail_level;
  logic          signal_q, busy_q, overflow_q;
  logic          req_valid, req_level, full, non_empty;
  logic          push, reject, pop;

  always_comb begin
    req_valid = (bus.event_code == 2'b01) || (bus.event_code == 2'b10);
    req_level = bus.event_code[0];
    full      = (count == (AW+1)'(DEPTH));
    non_empty = (count != '0);
    // Redundant requests never reach the FIFO, so they can never cause an overflow.
    push      = req_valid && (req_level != tail_level) && !full;
    reject    = req_valid && (req_level != tail_level) && full;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (non_empty) begin
          pop       = 1'b1;
          cnt_nxt   = CW'(HOLD_CYCLES - 1);
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (non_empty) begin
          pop     = 1'b1;
          cnt_nxt = CW'(HOLD_CYCLES - 1);
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tail_level <= INIT_LEVEL;
      signal_q   <= INIT_LEVEL;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      count      <= count_nxt;
      overflow_q <= reject;
      busy_q     <= (state_nxt == HOLD) || (count_nxt != '0);
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        tail_level <= req_level;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        signal_q <= mem[rd_ptr];
      end
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_level;
  end

  assign bus.signal   = signal_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_edge_event_player.sv
// tb/tb_edge_event_player.sv - scoreboard bench for edge_event_player
module tb_edge_event_player;
  typedef struct packed {
    int   e;
    logic v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   edge_n = 0;
  int   base = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sig_q[$];
  exp_t busy_q[$];
  exp_t ovf_q[$];
  logic p_sig, p_busy, p_ovf;

  edge_event_player_if bus ();

  edge_event_player #(.HOLD_CYCLES(4), .DEPTH(4), .INIT_LEVEL(1'b0)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: every observed change of an output is matched against the next expected change.
  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) begin
      p_sig = 1'b0; p_busy = 1'b0; p_ovf = 1'b0;
    end else begin
      if (bus.signal !== p_sig) begin
        total++;
        if (sig_q.size() == 0) begin
          bad++; $display("FAIL signal_unexpected edge=%0d got=%b want=no change", edge_n - base, bus.signal);
        end else begin
          x = sig_q.pop_front();
          if (x.e != edge_n || x.v !== bus.signal) begin
            bad++; $display("FAIL signal_change got edge=%0d val=%b want edge=%0d val=%b", edge_n - base, bus.signal, x.e - base, x.v);
          end
        end
        p_sig = bus.signal;
      end
      if (bus.busy !== p_busy) begin
        total++;
        if (busy_q.size() == 0) begin
          bad++; $display("FAIL busy_unexpected edge=%0d got=%b want=no change", edge_n - base, bus.busy);
        end else begin
          x = busy_q.pop_front();
          if (x.e != edge_n || x.v !== bus.busy) begin
            bad++; $display("FAIL busy_change got edge=%0d val=%b want edge=%0d val=%b", edge_n - base, bus.busy, x.e - base, x.v);
          end
        end
        p_busy = bus.busy;
      end
      if (bus.overflow !== p_ovf) begin
        total++;
        if (ovf_q.size() == 0) begin
          bad++; $display("FAIL overflow_unexpected edge=%0d got=%b want=no change", edge_n - base, bus.overflow);
        end else begin
          x = ovf_q.pop_front();
          if (x.e != edge_n || x.v !== bus.overflow) begin
            bad++; $display("FAIL overflow_change got edge=%0d val=%b want edge=%0d val=%b", edge_n - base, bus.overflow, x.e - base, x.v);
          end
        end
        p_ovf = bus.overflow;
      end
    end
  end

  task automatic check(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++; $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic exp_sig(input int rel, input logic v);
    sig_q.push_back('{e: base + rel, v: v});
  endtask
  task automatic exp_busy(input int rel, input logic v);
    busy_q.push_back('{e: base + rel, v: v});
  endtask
  task automatic exp_ovf(input int rel, input logic v);
    ovf_q.push_back('{e: base + rel, v: v});
  endtask

  task automatic apply(input int rel, input logic [1:0] code);
    while (edge_n < base + rel - 1) @(negedge clk);
    bus.event_code = code;
    @(negedge clk);
    bus.event_code = 2'b00;
  endtask

  task automatic wait_rel(input int rel);
    while (edge_n < base + rel) @(negedge clk);
  endtask

  task automatic drained(input string name);
    total++;
    if (sig_q.size() != 0 || busy_q.size() != 0 || ovf_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing got pending sig=%0d busy=%0d ovf=%0d want all 0", name, sig_q.size(), busy_q.size(), ovf_q.size());
    end
    sig_q.delete(); busy_q.delete(); ovf_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_signal", bus.signal, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_overflow", bus.overflow, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = edge_n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.event_code = 2'b00;
    repeat (2) @(negedge clk);
    check("init_signal", bus.signal, 1'b0);
    check("init_busy", bus.busy, 1'b0);
    check("init_overflow", bus.overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    base = edge_n;

    // Quiet after reset
    wait_rel(20);
    check("quiet_signal", bus.signal, 1'b0);
    check("quiet_busy", bus.busy, 1'b0);
    check("quiet_overflow", bus.overflow, 1'b0);
    drained("quiet");

    // Single rise
    do_reset();
    exp_busy(10, 1'b1); exp_sig(11, 1'b1); exp_busy(15, 1'b0);
    apply(10, 2'b01);
    wait_rel(30);
    drained("single");

    // Burst
    do_reset();
    exp_busy(10, 1'b1);
    exp_sig(11, 1'b1); exp_sig(15, 1'b0); exp_sig(19, 1'b1);
    exp_busy(23, 1'b0);
    apply(10, 2'b01); apply(11, 2'b10); apply(12, 2'b01);
    wait_rel(35);
    drained("burst");

    // Redundant event, no-op codes, then a fall
    do_reset();
    exp_busy(10, 1'b1); exp_sig(11, 1'b1); exp_busy(15, 1'b0);
    exp_busy(24, 1'b1); exp_sig(25, 1'b0); exp_busy(29, 1'b0);
    apply(10, 2'b01); apply(12, 2'b01); apply(14, 2'b11);
    apply(20, 2'b11); apply(22, 2'b00); apply(24, 2'b10);
    wait_rel(40);
    check("redund_level", bus.signal, 1'b0);
    drained("redund");

    // Overflow
    do_reset();
    exp_busy(10, 1'b1);
    exp_sig(11, 1'b1); exp_sig(15, 1'b0); exp_sig(19, 1'b1); exp_sig(23, 1'b0); exp_sig(27, 1'b1);
    exp_ovf(15, 1'b1); exp_ovf(16, 1'b0);
    exp_busy(31, 1'b0);
    apply(10, 2'b01); apply(11, 2'b10); apply(12, 2'b01);
    apply(13, 2'b10); apply(14, 2'b01); apply(15, 2'b10);
    wait_rel(45);
    check("ovf_final_level", bus.signal, 1'b1);
    drained("overflow");

    // Reset in the middle of a hold
    do_reset();
    exp_busy(10, 1'b1); exp_sig(11, 1'b1);
    apply(10, 2'b01); apply(11, 2'b10); apply(12, 2'b01);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_signal", bus.signal, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_quiet_signal", bus.signal, 1'b0);
    check("midrst_quiet_busy", bus.busy, 1'b0);
    drained("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
